// File: rtl/cdb_tx_buffer.sv
// Per-FU result staging FIFO feeding one slot of the CDB arbiter (fu_done/wr_data/stall_sig).
// Optional same-cycle bypass through an empty buffer: define CDB_TX_BYPASS_EN.

package cdb_pkg;
    typedef struct packed {
        logic [4:0]  reg_idx;
        logic [5:0]  p_reg_idx;
        logic [31:0] reg_val;
        logic        valid;
    } FU_PACKET;
endpackage

module cdb_tx_buffer
    import cdb_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             fu_valid,
    input  FU_PACKET         fu_packet,
    output logic             fu_ready,
    input  logic             squash,
    input  logic             stall_sig,
    output logic             fu_done,
    output FU_PACKET         wr_data,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    FU_PACKET         mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             empty;
    logic             bypass;
    logic             bcast_in;
    logic             push;
    logic             pop;
    FU_PACKET         push_pkt;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty = (count == '0);

`ifdef CDB_TX_BYPASS_EN
    assign bypass = empty & fu_valid;
`else
    assign bypass = 1'b0;
`endif

    always_comb begin
        push_pkt       = fu_packet;
        push_pkt.valid = 1'b1;
    end

    // Granted head frees its slot in the same cycle, so fu_ready sees stall_sig combinationally.
    always_comb begin
        fu_done  = 1'b0;
        wr_data  = '0;
        fu_ready = 1'b0;
        pop      = 1'b0;
        bcast_in = 1'b0;
        push     = 1'b0;
        if (!reset && !squash) begin
            if (!empty) begin
                fu_done = 1'b1;
                wr_data = mem[head];
            end else if (bypass) begin
                fu_done = 1'b1;
                wr_data = push_pkt;
            end
            pop      = ~empty & ~stall_sig;
            bcast_in = bypass & ~stall_sig;
            fu_ready = (count < FULL_CNT) | pop;
            push     = fu_valid & fu_ready & ~bcast_in;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            mem   <= '{default: '0};
        end else if (squash) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[tail] <= push_pkt;
                tail      <= ptr_inc(tail);
            end
            if (pop) begin
                head <= ptr_inc(head);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
